// File: rtl/ysyx_25060170_lsu_pkg.sv
// ysyx_25060170_pkg: shared LSU state encoding, funct3 load/store constants
// and access-size helpers used by the LSU top and its alignment unit.
// No ports; imported with `import ysyx_25060170_pkg::*;`.
package ysyx_25060170_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unsigned variants only exist for loads; on a store 100/101 are not
  // valid encodings and fall back to a full word like any other unknown.
  function automatic lsu_size_e access_size(input logic [2:0] funct3,
                                            input logic       is_store);
    lsu_size_e sz;
    case (funct3)
      F3_LB:   sz = SZ_BYTE;
      F3_LH:   sz = SZ_HALF;
      F3_LBU:  sz = is_store ? SZ_WORD : SZ_BYTE;
      F3_LHU:  sz = is_store ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz,
                                         input logic [1:0] addr_lo);
    return ((sz == SZ_HALF) && addr_lo[0]) ||
           ((sz == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_25060170_lsu_if.sv
// ysyx_25060170_lsu_if: bundles the EXU->LSU request, LSU<->memory and
// LSU->WBU response signals. Modport slave is the LSU view, modport master
// is the surrounding pipeline/memory view.
interface ysyx_25060170_lsu_if;

  // upstream (EXU)
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  funct3_i;
  logic        is_load_i;
  logic        is_store_i;
  logic [4:0]  rd_i;

  // memory
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  // downstream (WBU)
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_o;
  logic        wb_en_o;
  logic        fault_o;

  modport slave (
    input  in_valid_i, addr_i, wdata_i, funct3_i, is_load_i, is_store_i, rd_i,
    output in_ready_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output out_valid_o, wb_data_o, rd_o, wb_en_o, fault_o,
    input  out_ready_i
  );

  modport master (
    output in_valid_i, addr_i, wdata_i, funct3_i, is_load_i, is_store_i, rd_i,
    input  in_ready_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  out_valid_o, wb_data_o, rd_o, wb_en_o, fault_o,
    output out_ready_i
  );

endinterface

// File: rtl/ysyx_25060170_lsu_align.sv
// ysyx_25060170_lsu_align: store byte-mask generation, store lane
// replication and load byte/halfword extraction with sign/zero extension.
// Purely combinational, no backpressure.
// Ports: funct3_i/is_store_i select the access size, addr_lo_i is the byte
// offset, wdata_i/rdata_i are raw store/load words; wmask_o, wdata_o and
// load_data_o are the aligned results.
module ysyx_25060170_lsu_align
  import ysyx_25060170_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  lsu_size_e   sz;
  logic [15:0] rd_shift;

  always_comb begin
    sz          = access_size(funct3_i, is_store_i);
    // Bring the addressed lane down to bit 0; a halfword at offset 3 sees
    // zeros above lane 3, which is the lane-truncation behaviour.
    rd_shift    = 16'(rdata_i >> {addr_lo_i, 3'b000});
    wmask_o     = 4'b1111;
    wdata_o     = wdata_i;
    load_data_o = rdata_i;
    case (sz)
      SZ_BYTE: begin
        wmask_o     = 4'b0001 << addr_lo_i;
        wdata_o     = {4{wdata_i[7:0]}};
        load_data_o = funct3_i[2] ? {24'b0, rd_shift[7:0]}
                                  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      SZ_HALF: begin
        wmask_o     = 4'b0011 << addr_lo_i;
        wdata_o     = {2{wdata_i[15:0]}};
        load_data_o = funct3_i[2] ? {16'b0, rd_shift}
                                  : {{16{rd_shift[15]}}, rd_shift};
      end
      default: begin
        wmask_o     = 4'b1111;
        wdata_o     = wdata_i;
        load_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// ysyx_25060170_lsu: single-outstanding load/store unit between EXU and WBU.
// Latency: accept N, mem_req N+1, out_valid N+3 (gnt/rvalid immediate);
//   non-memory ops and faults present out_valid at N+1.
// Backpressure: in_ready only in IDLE; response held in RESP until out_ready.
// Ports: clk, rst (async, active-high), bus (ysyx_25060170_lsu_if.slave).
// Macro YSYX_25060170_LSU_MISALIGN_CHECK_EN: misaligned half/word accesses
//   skip memory and respond with fault_o=1; otherwise fault_o is tied low.
module ysyx_25060170_lsu
  import ysyx_25060170_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_25060170_lsu_if.slave      bus
);

  lsu_state_e      state_q, state_d;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            is_store_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            wb_en_q;

  logic            accept;
  logic            is_mem_in;
  logic            fault_in;

  logic [3:0]      al_wmask;
  logic [31:0]     al_wdata;
  logic [31:0]     al_load;

  assign accept    = (state_q == S_IDLE) && bus.in_valid_i;
  assign is_mem_in = bus.is_load_i | bus.is_store_i;

`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
  logic fault_q;
  assign fault_in = is_mem_in &&
                    is_misaligned(access_size(bus.funct3_i, bus.is_store_i),
                                  bus.addr_i[1:0]);
`else
  assign fault_in = 1'b0;
`endif

  // Operates on latched fields so mask/data stay stable across REQ.
  ysyx_25060170_lsu_align u_align (
    .funct3_i    (funct3_q),
    .is_store_i  (is_store_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_i     (bus.mem_rdata_i),
    .wmask_o     (al_wmask),
    .wdata_o     (al_wdata),
    .load_data_o (al_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid_i) state_d = (is_mem_in && !fault_in) ? S_REQ : S_RESP;
      // An rvalid coincident with gnt belongs to nothing yet; only gnt counts.
      S_REQ:  if (bus.mem_gnt_i)    state_d = S_WAIT;
      S_WAIT: if (bus.mem_rvalid_i) state_d = S_RESP;
      S_RESP: if (bus.out_ready_i)  state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_en_q    <= 1'b0;
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else if (accept) begin
      addr_q     <= bus.addr_i;
      wdata_q    <= bus.wdata_i;
      funct3_q   <= bus.funct3_i;
      is_store_q <= bus.is_store_i;
      rd_q       <= bus.rd_i;
      if (!is_mem_in) begin
        wb_data_q <= bus.addr_i;
        wb_en_q   <= (bus.rd_i != 5'd0);
      end else if (fault_in) begin
        wb_data_q <= '0;
        wb_en_q   <= 1'b0;
      end else begin
        wb_data_q <= '0;
        wb_en_q   <= bus.is_load_i & ~bus.is_store_i & (bus.rd_i != 5'd0);
      end
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
      fault_q    <= fault_in;
`endif
    end else if ((state_q == S_WAIT) && bus.mem_rvalid_i) begin
      wb_data_q <= is_store_q ? '0 : al_load;
    end
  end

  // Outputs are gated by state so everything reads zero outside the phase
  // that owns it, including during reset.
  always_comb begin
    bus.in_ready_o  = (state_q == S_IDLE);
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_wmask_o = '0;
    bus.out_valid_o = 1'b0;
    bus.wb_data_o   = '0;
    bus.rd_o        = '0;
    bus.wb_en_o     = 1'b0;
    bus.fault_o     = 1'b0;
    if (state_q == S_REQ) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = is_store_q;
      bus.mem_addr_o  = {addr_q[31:2], 2'b00};
      bus.mem_wdata_o = al_wdata;
      bus.mem_wmask_o = al_wmask;
    end
    if (state_q == S_RESP) begin
      bus.out_valid_o = 1'b1;
      bus.wb_data_o   = wb_data_q;
      bus.rd_o        = rd_q;
      bus.wb_en_o     = wb_en_q;
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
      bus.fault_o     = fault_q;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
module tb_ysyx_25060170_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25060170_lsu_if bus();

  ysyx_25060170_lsu #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input bit ld, input logic [2:0] f3);
    if (f3 == 3'b000) return 1;
    if (f3 == 3'b001) return 2;
    if (ld && f3 == 3'b100) return 1;
    if (ld && f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_mask(input int n, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    if (n == 4) return 4'b1111;
    for (int b = 0; b < 4; b++)
      if (b >= int'(a) && b < int'(a) + n) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] wd);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input int n, input logic [2:0] f3,
                                         input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int idx;
    if (n == 4) return rd;
    v = '0;
    for (int k = 0; k < n; k++) begin
      idx = int'(a) + k;
      if (idx < 4) v[8*k +: 8] = rd[8*idx +: 8];
    end
    if (!f3[2] && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit m_fault(input bit mem, input int n, input logic [1:0] a);
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
    return mem && ((n == 2 && a[0]) || (n == 4 && a != 2'b00));
`else
    return 1'b0 & mem & (n == 0) & a[0];
`endif
  endfunction

  task automatic scramble();
    bus.addr_i     = $urandom;
    bus.wdata_i    = $urandom;
    bus.funct3_i   = 3'($urandom);
    bus.is_load_i  = 1'($urandom);
    bus.is_store_i = 1'($urandom);
    bus.rd_i       = 5'($urandom);
  endtask

  // Drives one operation from IDLE and checks every cycle until IDLE again.
  // Called and returns on a negedge.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int gd, input int rvd,
                        input int rdyd, input logic [31:0] rdata,
                        input bit dual, input string tag);
    bit          mem;
    int          n;
    bit          flt;
    logic [31:0] exp_wb;
    logic        exp_en;
    mem = ld | st;
    n   = nbytes(ld, f3);
    flt = m_fault(mem, n, addr[1:0]);
    if (!mem)      begin exp_wb = addr; exp_en = (rd != 0); end
    else if (flt)  begin exp_wb = '0;   exp_en = 1'b0;      end
    else if (st)   begin exp_wb = '0;   exp_en = 1'b0;      end
    else           begin exp_wb = m_load(n, f3, addr[1:0], rdata); exp_en = (rd != 0); end

    chk({tag, ".idle_rdy"}, 32'(bus.in_ready_o), 32'd1);
    bus.in_valid_i = 1'b1;
    bus.addr_i = addr; bus.wdata_i = wd; bus.funct3_i = f3;
    bus.is_load_i = ld; bus.is_store_i = st; bus.rd_i = rd;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    scramble();
    if (mem && !flt) begin
      for (int i = 0; i <= gd; i++) begin
        chk({tag, ".req"},   32'(bus.mem_req_o), 32'd1);
        chk({tag, ".we"},    32'(bus.mem_we_o), 32'(st));
        chk({tag, ".maddr"}, bus.mem_addr_o, {addr[31:2], 2'b00});
        if (st) begin
          chk({tag, ".mask"},   32'(bus.mem_wmask_o), 32'(m_mask(n, addr[1:0])));
          chk({tag, ".mwdata"}, bus.mem_wdata_o, m_wdata(n, wd));
        end
        chk({tag, ".req_rdy"},  32'(bus.in_ready_o), 32'd0);
        chk({tag, ".req_oval"}, 32'(bus.out_valid_o), 32'd0);
        bus.mem_gnt_i    = (i == gd);
        bus.mem_rvalid_i = (i == gd) && dual;
        bus.mem_rdata_i  = $urandom;
        @(negedge clk);
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
      end
      for (int j = 0; j <= rvd; j++) begin
        chk({tag, ".wait_req"},  32'(bus.mem_req_o), 32'd0);
        chk({tag, ".wait_oval"}, 32'(bus.out_valid_o), 32'd0);
        chk({tag, ".wait_rdy"},  32'(bus.in_ready_o), 32'd0);
        bus.mem_rvalid_i = (j == rvd);
        bus.mem_rdata_i  = (j == rvd) ? rdata : $urandom;
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = $urandom;
      end
    end
    for (int k = 0; k <= rdyd; k++) begin
      chk({tag, ".oval"},   32'(bus.out_valid_o), 32'd1);
      chk({tag, ".wbdata"}, bus.wb_data_o, exp_wb);
      chk({tag, ".wben"},   32'(bus.wb_en_o), 32'(exp_en));
      chk({tag, ".rd"},     32'(bus.rd_o), 32'(rd));
      chk({tag, ".fault"},  32'(bus.fault_o), 32'(flt));
      chk({tag, ".resp_rdy"}, 32'(bus.in_ready_o), 32'd0);
      chk({tag, ".resp_req"}, 32'(bus.mem_req_o), 32'd0);
      bus.out_ready_i = (k == rdyd);
      @(negedge clk);
      bus.out_ready_i = 1'b0;
    end
    chk({tag, ".done_oval"}, 32'(bus.out_valid_o), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rdy"},   32'(bus.in_ready_o), 32'd1);
    chk({tag, ".req"},   32'(bus.mem_req_o), 32'd0);
    chk({tag, ".we"},    32'(bus.mem_we_o), 32'd0);
    chk({tag, ".oval"},  32'(bus.out_valid_o), 32'd0);
    chk({tag, ".wben"},  32'(bus.wb_en_o), 32'd0);
    chk({tag, ".fault"}, 32'(bus.fault_o), 32'd0);
    chk({tag, ".maddr"}, bus.mem_addr_o, 32'd0);
    chk({tag, ".mwd"},   bus.mem_wdata_o, 32'd0);
    chk({tag, ".mask"},  32'(bus.mem_wmask_o), 32'd0);
    chk({tag, ".wbd"},   bus.wb_data_o, 32'd0);
    chk({tag, ".rd"},    32'(bus.rd_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    scramble();
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // LW, immediate gnt/rvalid -> out_valid at N+3
    run_op(1, 0, 3'b010, 32'h8000_0004, 32'h0, 5'd3, 0, 0, 0, 32'hDEAD_BEEF, 0, "lw");
    run_op(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 0, 0, 0, 32'h8011_2233, 0, "lb");
    run_op(1, 0, 3'b100, 32'h8000_0003, 32'h0, 5'd5, 0, 0, 0, 32'h8011_2233, 0, "lbu");
    run_op(0, 1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 5'd7, 0, 0, 0, 32'h0, 0, "sh");
    // gnt delayed 3 cycles, out_ready low 2 cycles
    run_op(1, 0, 3'b101, 32'h8000_0002, 32'h0, 5'd9, 3, 1, 2, 32'hF00D_8001, 0, "lhu_slow");
    run_op(1, 0, 3'b001, 32'h8000_0000, 32'h0, 5'd9, 0, 2, 0, 32'h1234_8765, 1, "lh_dual");
    run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd1, 0, 0, 1, 32'h0, 0, "alu");
    run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 5'd0, 0, 0, 0, 32'h0, 0, "alu_x0");
    run_op(1, 0, 3'b010, 32'h8000_0010, 32'h0, 5'd0, 0, 0, 0, 32'hCAFE_F00D, 0, "lw_x0");
    run_op(0, 1, 3'b000, 32'h8000_0001, 32'h0000_005A, 5'd2, 1, 0, 0, 32'h0, 0, "sb");
    run_op(0, 1, 3'b111, 32'h8000_0008, 32'h0102_0304, 5'd2, 0, 0, 0, 32'h0, 0, "sw_unsup");
    // misaligned word: fault when checking is enabled, plain LW otherwise
    run_op(1, 0, 3'b010, 32'h8000_0002, 32'h0, 5'd4, 0, 0, 0, 32'h1122_3344, 0, "lw_mis");
    run_op(1, 0, 3'b001, 32'h8000_0003, 32'h0, 5'd4, 0, 0, 0, 32'h8122_3344, 0, "lh_mis");

    // reset while waiting for rvalid
    bus.in_valid_i = 1'b1; bus.addr_i = 32'h8000_0020; bus.wdata_i = '0;
    bus.funct3_i = 3'b010; bus.is_load_i = 1'b1; bus.is_store_i = 1'b0; bus.rd_i = 5'd6;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    chk("rstw.req", 32'(bus.mem_req_o), 32'd1);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    chk("rstw.wait_req", 32'(bus.mem_req_o), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rstw.async");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstw.late_oval", 32'(bus.out_valid_o), 32'd0);
      chk("rstw.late_rdy",  32'(bus.in_ready_o), 32'd1);
      @(negedge clk);
    end

    // randomized operations against the model
    for (int t = 0; t < 40; t++) begin
      int          kind;
      logic [2:0]  f3;
      kind = int'($urandom_range(0, 2));
      f3   = 3'($urandom);
      run_op(kind == 1, kind == 2, f3, $urandom, $urandom, 5'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), $urandom, 1'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_lsu.md
YSYX_25060170_LSU -- requirements
Module: ysyx_25060170_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports in_valid_i in 1 and in_ready_o out 1, the upstream handshake from EXU.
REQ-005 SHALL have ports addr_i in 32 (EXU ALU result), wdata_i in 32 (rs2 data), funct3_i in 3, is_load_i in 1, is_store_i in 1, rd_i in 5.
REQ-006 SHALL have memory ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out 32 (word-aligned), mem_wdata_o out 32, mem_wmask_o out 4, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32.
REQ-007 SHALL have ports out_valid_o out 1, out_ready_i in 1, wb_data_o out 32, rd_o out 5, wb_en_o out 1, fault_o out 1, the downstream handshake to WBU.

Function
REQ-008 SHALL implement FSM IDLE, REQ, WAIT, RESP; in_ready_o=1 only in IDLE.
REQ-009 SHALL, in IDLE on in_valid_i, latch all inputs; go to REQ if load/store, else RESP with wb_data_o=addr_i, wb_en_o=(rd_i!=0).
REQ-010 SHALL hold mem_req_o=1 with stable address/data/mask throughout REQ; move to WAIT in the cycle mem_gnt_i=1.
REQ-011 SHALL, in WAIT, move to RESP in the cycle mem_rvalid_i=1, capturing mem_rdata_i; mem_rvalid_i and mem_gnt_i in the same cycle in REQ SHALL be treated as gnt only.
REQ-012 SHALL hold out_valid_o=1 and all outputs stable in RESP until out_ready_i=1, then return to IDLE; no skid path, so one transfer is in flight at a time.
REQ-013 SHALL give stores wmask: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; wdata replicated into lanes; wb_en_o=0.
REQ-014 SHALL extract loads by funct3 from addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; wb_en_o=(rd!=0).
REQ-015 SHALL treat an unsupported funct3 as LW/SW.
REQ-016 SHALL give minimum latency: accept N, mem_req_o N+1, gnt N+1, rvalid N+2, out_valid_o N+3; non-memory ops out_valid_o at N+1.

Reset
REQ-017 SHALL, while rst=1, force state IDLE and in_ready_o=1; mem_req_o, mem_we_o, out_valid_o, wb_en_o and fault_o SHALL be 0; all data outputs SHALL be 0.
REQ-018 SHALL abandon any in-flight access on rst mid-operation; no response is issued for it after reset releases.

Configuration
REQ-019 SHALL support macro YSYX_25060170_LSU_MISALIGN_CHECK_EN.
REQ-020 SHALL, with the macro defined, treat halfword at addr[0]=1 or word at addr[1:0]!=0 as misaligned: skip REQ/WAIT, go to RESP with fault_o=1 and wb_en_o=0.
REQ-021 SHALL, without the macro, tie fault_o to 0 and issue accesses with lane truncation (bytes beyond lane 3 dropped).

Structure
REQ-022 SHALL place the state encoding and funct3 load/store constants (LB=000, LH=001, LW=010, LBU=100, LHU=101) in shared package ysyx_25060170_pkg.
REQ-023 SHALL use one combinational sub-module ysyx_25060170_lsu_align for mask generation, lane replication and load extraction.

Verification
REQ-024 SHALL cover: LW addr 0x80000004, mem_rdata 0xDEADBEEF, gnt and rvalid immediate -> wb_data 0xDEADBEEF, wb_en 1, out_valid at N+3.
REQ-025 SHALL cover: LB addr 0x80000003, rdata 0x80112233 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-026 SHALL cover: SH addr 0x80000002, wdata 0x0000ABCD -> wmask 4'b1100, mem_wdata 0xABCDABCD, mem_we 1, wb_en 0.
REQ-027 SHALL cover: gnt delayed 3 cycles and out_ready_i low 2 cycles -> mem_req and outputs stable, in_ready_o 0 throughout.
REQ-028 SHALL cover: rst asserted in WAIT -> immediate IDLE, mem_req 0, no out_valid after a late rvalid.
REQ-029 SHALL cover, with the macro defined: LW addr 0x80000002 -> no mem_req, fault_o 1 at N+1.
